// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M types for the EX-stage multiply/divide unit: FSM states, M-op encodings, signedness helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3_t;

    function automatic logic op_a_signed(input m_funct3_t f);
        logic s;
        case (f)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic op_b_signed(input m_funct3_t f);
        logic s;
        case (f)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_divider.sv
// Restoring unsigned divider core: one quotient bit per cycle on captured magnitudes.
module iter_divider #(
    parameter int  XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic             running_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  dvs_r;
    logic [XLEN:0]    shifted_s;
    logic [XLEN:0]    trial_s;

    assign shifted_s = {rem_r, quo_r[XLEN-1]};
    assign trial_s   = shifted_s - {1'b0, dvs_r};
    assign last      = running_r && (cnt_r == '0);

    // Trial subtraction: keep the difference when it does not go negative.
    always_comb begin
        rem_next = shifted_s[XLEN-1:0];
        quo_next = {quo_r[XLEN-2:0], 1'b0};
        if (!trial_s[XLEN]) begin
            rem_next = trial_s[XLEN-1:0];
            quo_next = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[XLEN-1:0];
        end
    end

    // Iteration registers; the counter is loaded on start and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_r <= 1'b0;
            cnt_r     <= '0;
            quo_r     <= '0;
            rem_r     <= '0;
            dvs_r     <= '0;
        end else if (flush) begin
            running_r <= 1'b0;
        end else if (start) begin
            running_r <= 1'b1;
            cnt_r     <= CNT_W'(XLEN-1);
            quo_r     <= dividend;
            rem_r     <= '0;
            dvs_r     <= divisor;
        end else if (running_r) begin
            quo_r <= quo_next;
            rem_r <= rem_next;
            if (last) begin
                running_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end else begin
            running_r <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide beside the EX ALU; stalls the front end while iterating.
// Optional build macro MUL_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module ex_muldiv_unit
    import rv32i_types::*;
#(
    parameter int  XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic            dstall,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ex_stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t      state_r;
    m_funct3_t          op_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*XLEN-1:0]  mcand_r;
    logic [XLEN-1:0]    mplier_r;
    logic [2*XLEN-1:0]  acc_r;
    logic               neg_r;
    logic               rneg_r;
    logic [XLEN-1:0]    result_r;

    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic               div_zero_s;
    logic               div_ovf_s;
    logic               div_start_s;
    logic [2*XLEN-1:0]  acc_next_s;
    logic [XLEN-1:0]    mplier_next_s;
    logic [2*XLEN-1:0]  prod_fix_s;
    logic [XLEN-1:0]    mul_res_s;
    logic               mul_last_s;
    logic               div_last_s;
    logic [XLEN-1:0]    quo_next_s;
    logic [XLEN-1:0]    rem_next_s;
    logic [XLEN-1:0]    quo_fix_s;
    logic [XLEN-1:0]    rem_fix_s;
    logic [XLEN-1:0]    div_res_s;

    assign a_neg_s     = op_a_signed(m_funct3_t'(funct3)) & a[XLEN-1];
    assign b_neg_s     = op_b_signed(m_funct3_t'(funct3)) & b[XLEN-1];
    assign a_mag_s     = a_neg_s ? -a : a;
    assign b_mag_s     = b_neg_s ? -b : b;
    assign div_zero_s  = (b == '0);
    assign div_ovf_s   = !funct3[0] && (a == MIN_VAL) && (b == '1);
    assign div_start_s = (state_r == ST_IDLE) && start && !flush && funct3[2]
                         && !div_zero_s && !div_ovf_s;

    assign acc_next_s    = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign mplier_next_s = mplier_r >> 1;
    assign prod_fix_s    = neg_r ? -acc_next_s : acc_next_s;
    assign mul_res_s     = (op_r == F3_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];

`ifdef MUL_EARLY_OUT_EN
    assign mul_last_s = (cnt_r == '0) || (mplier_next_s == '0);
`else
    assign mul_last_s = (cnt_r == '0);
`endif

    assign quo_fix_s = neg_r  ? -quo_next_s : quo_next_s;
    assign rem_fix_s = rneg_r ? -rem_next_s : rem_next_s;
    assign div_res_s = op_r[1] ? rem_fix_s : quo_fix_s;

    iter_divider #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start    (div_start_s),
        .dividend (a_mag_s),
        .divisor  (b_mag_s),
        .last     (div_last_s),
        .quo_next (quo_next_s),
        .rem_next (rem_next_s)
    );

    // Control FSM plus shift-add multiplier datapath; result is loaded on the edge into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            op_r     <= F3_MUL;
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            result_r <= '0;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r     <= m_funct3_t'(funct3);
                        cnt_r    <= CNT_W'(XLEN-1);
                        mcand_r  <= {{XLEN{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        acc_r    <= '0;
                        neg_r    <= a_neg_s ^ b_neg_s;
                        rneg_r   <= a_neg_s;
                        if (!funct3[2]) begin
                            state_r <= ST_MUL;
                        end else if (div_zero_s) begin
                            result_r <= funct3[1] ? a : '1;
                            state_r  <= ST_DONE;
                        end else if (div_ovf_s) begin
                            result_r <= funct3[1] ? '0 : MIN_VAL;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r <= ST_DIV;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_next_s;
                    if (mul_last_s) begin
                        result_r <= mul_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (div_last_s) begin
                        result_r <= div_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_DONE: begin
                    if (!dstall) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state_r == ST_MUL) || (state_r == ST_DIV);
    assign result_valid = (state_r == ST_DONE);
    assign ex_stall     = start && (state_r != ST_DONE);
    assign result       = result_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (XLEN=32): directed M-ops, flush, dstall hold, async reset, random ops.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush, dstall;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        ex_stall, busy, result_valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] MINV = 32'h8000_0000;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .dstall(dstall),
        .funct3(funct3), .a(a), .b(b), .ex_stall(ex_stall), .busy(busy),
        .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, p;
        longint unsigned up;
        int ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = int'(x);
        iy = int'(y);
        case (f)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * longint'({32'd0, y}); return p[63:32]; end
            3'b011: begin up = {32'd0, x} * {32'd0, y}; return up[63:32]; end
            3'b100: return (y == 32'd0) ? 32'hFFFF_FFFF : (x == MINV && y == 32'hFFFF_FFFF) ? MINV : 32'(ix / iy);
            3'b101: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'b110: return (y == 32'd0) ? x : (x == MINV && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(ix % iy);
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] m;
        int n;
        if (f[2]) return (y == 32'd0 || (!f[0] && x == MINV && y == 32'hFFFF_FFFF)) ? 1 : 33;
        m = ((f == 3'b000 || f == 3'b001) && y[31]) ? -y : y;
        n = 32;
`ifdef MUL_EARLY_OUT_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`endif
        if (m == 32'd0) n = n;  // keeps m referenced in the default build
        return n + 1;
    endfunction

    // Caller is at a negedge in an IDLE cycle; this is cycle 0.
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int hold);
        int cyc, lat, bad_stall;
        logic [31:0] held;
        exp_q.push_back(model(f, x, y));
        lat = exp_lat(f, x, y);
        start = 1'b1; funct3 = f; a = x; b = y;
        #1 chk("stall_c0", ex_stall, 1'b1);
        cyc = 0;
        bad_stall = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a = ~x; b = y ^ 32'h5A5A_0001; funct3 = ~f;
            end
            if (result_valid || cyc > 200) break;
            if (!ex_stall) bad_stall++;
        end
        chk("valid_seen", result_valid, 1'b1);
        chk("latency", cyc, lat);
        chk("stall_while_busy", bad_stall, 0);
        chk("stall_done", ex_stall, 1'b0);
        held = exp_q.pop_front();
        chk($sformatf("res_f%0d_%h_%h", f, x, y), result, held);
        if (hold > 0) begin
            dstall = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", result_valid, 1'b1);
                chk("hold_result", result, held);
                chk("hold_stall", ex_stall, 1'b0);
            end
        end
        dstall = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_valid", result_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int seen_valid;
        rst = 1'b1; start = 1'b0; flush = 1'b0; dstall = 1'b0;
        funct3 = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", ex_stall, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'b001, MINV, MINV, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'b000, 32'd5, 32'd3, 0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'b101, 32'd100, 32'd7, 0);
        run_op(3'b111, 32'd100, 32'd7, 0);
        run_op(3'b100, 32'd5, 32'd0, 0);
        run_op(3'b110, 32'd5, 32'd0, 0);
        run_op(3'b100, MINV, 32'hFFFF_FFFF, 0);
        run_op(3'b110, MINV, 32'hFFFF_FFFF, 0);
        run_op(3'b101, 32'hDEAD_BEEF, 32'd0, 0);

        // Flush a divide in cycle 10; the next MUL goes in on cycle 11.
        start = 1'b1; funct3 = 3'b100; a = 32'd1000; b = 32'd3;
        seen_valid = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (result_valid) seen_valid++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_busy", busy, 1'b0);
        chk("flush_no_valid", seen_valid + int'(result_valid), 0);
        run_op(3'b000, 32'd12, 32'hFFFF_FFF0, 0);

        run_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 3);

        // Async reset mid-multiply.
        start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'hFFFF_FFFF;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", result_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_result", result, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            logic [2:0] f;
            logic [31:0] x, y;
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = (k % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(f, x, y, k % 3);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
